// File: rtl/dsp_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_dot_sequencer
// Purpose  : Drives one DSP48E2 wrapper to compute signed dot products
//            P = sum(a[i]*b[i]) over a programmable number of operand pairs.
//            Operands stream in with valid/ready; the 48-bit result leaves
//            with valid/ready. OPMODE is delayed to line up with the slice's
//            A/B and M registers so each product meets its own tag.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_dot_sequencer #(
    parameter int INPUTREG   = 1,
    parameter int DSPPIPEREG = 1,
    parameter int OUTPUTREG  = 1,
    parameter int CONTROLREG = 1,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [26:0]       in_a,
    input  logic [17:0]       in_b,
    output logic              dsp_rst,
    output logic              dsp_enable,
    output logic [29:0]       dsp_a,
    output logic [17:0]       dsp_b,
    output logic [47:0]       dsp_c,
    output logic [26:0]       dsp_d,
    output logic [8:0]        dsp_opmode,
    output logic [4:0]        dsp_inmode,
    output logic [3:0]        dsp_alumode,
    input  logic [47:0]       dsp_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [47:0]       out_data
);

    // Steps between tag insertion and the slice's OPMODE register needing it.
    localparam int OPDLY = INPUTREG + DSPPIPEREG - CONTROLREG;
    // Steps from operand issue until P reflects that operand.
    localparam int LAT   = INPUTREG + DSPPIPEREG + OUTPUTREG;
    localparam int DRN_W = $clog2(LAT + 2);

    localparam logic [8:0] OP_FIRST = 9'h005;   // P = M
    localparam logic [8:0] OP_ACC   = 9'h025;   // P = P + M

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRN_W-1:0]   r_drain;
    logic               r_first;
    logic               w_issue;
    logic [8:0]         w_tag;

    // Constant slice configuration: A2*B2 multiply, ALU add, C/D unused.
    assign dsp_rst     = ~rst_n;
    assign dsp_c       = 48'd0;
    assign dsp_d       = 27'd0;
    assign dsp_inmode  = 5'b00000;
    assign dsp_alumode = 4'b0000;

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_OUT);

    // Drain and bubble slots present zero operands so the ACC tag leaves P unchanged.
    assign dsp_a = w_issue ? {{3{in_a[26]}}, in_a} : 30'd0;
    assign dsp_b = w_issue ? in_b : 18'd0;
    assign w_tag = (w_issue && r_first) ? OP_FIRST : OP_ACC;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus handshake and slice-enable outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        dsp_enable  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (len != '0) ? S_RUN : S_OUT;
                end
            end
            S_RUN: begin
                in_ready   = 1'b1;
                dsp_enable = in_valid;
                w_issue    = in_valid;
                if (in_valid && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Count zero means this is the capture cycle: slice stays frozen.
                if (r_drain != '0) begin
                    dsp_enable = 1'b1;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job counters, first-pair flag and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_drain     <= '0;
            r_first     <= 1'b0;
            out_data    <= 48'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= len;
                        r_first     <= 1'b1;
                        if (len == '0) begin
                            out_data <= 48'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_first     <= 1'b0;
                        if (r_remaining == LEN_W'(1)) begin
                            r_drain <= DRN_W'(LAT);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain != '0) begin
                        r_drain <= r_drain - DRN_W'(1);
                    end else begin
                        out_data <= dsp_p;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (OPDLY == 0) begin : g_opdly_bypass
            assign dsp_opmode = w_tag;
        end else begin : g_opdly
            logic [8:0] r_opdly [OPDLY];

            // Tag delay line; shifts only on steps so it stalls with the slice.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < OPDLY; i++) begin
                        r_opdly[i] <= OP_ACC;
                    end
                end else if (dsp_enable) begin
                    r_opdly[0] <= w_tag;
                    for (int i = 1; i < OPDLY; i++) begin
                        r_opdly[i] <= r_opdly[i-1];
                    end
                end
            end

            assign dsp_opmode = r_opdly[OPDLY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dsp_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_dot_sequencer
// Purpose  : Self-checking bench for dsp_dot_sequencer with a behavioural
//            DSP48E2 model (A/B, M, OPMODE and P registers, all on enable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_dot_sequencer;

    localparam logic [8:0] OP_FIRST = 9'h005;
    localparam logic [8:0] OP_ACC   = 9'h025;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        dsp_rst;
    logic        dsp_enable;
    logic [29:0] dsp_a;
    logic [17:0] dsp_b;
    logic [47:0] dsp_c;
    logic [26:0] dsp_d;
    logic [8:0]  dsp_opmode;
    logic [4:0]  dsp_inmode;
    logic [3:0]  dsp_alumode;
    logic [47:0] dsp_p;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_data;

    dsp_dot_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_rst(dsp_rst), .dsp_enable(dsp_enable), .dsp_a(dsp_a), .dsp_b(dsp_b),
        .dsp_c(dsp_c), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
        .dsp_inmode(dsp_inmode), .dsp_alumode(dsp_alumode), .dsp_p(dsp_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Behavioural slice: INPUTREG=1, DSPPIPEREG=1, CONTROLREG=1, OUTPUTREG=1.
    logic signed [29:0] m_a;
    logic signed [17:0] m_b;
    logic signed [47:0] m_m;
    logic [8:0]         m_op;
    logic [47:0]        m_p;
    always @(posedge clk) begin
        if (dsp_rst) begin
            m_a <= '0; m_b <= '0; m_m <= '0; m_op <= OP_ACC; m_p <= '0;
        end else if (dsp_enable) begin
            m_a  <= dsp_a;
            m_b  <= dsp_b;
            m_m  <= 48'(m_a) * 48'(m_b);
            m_op <= dsp_opmode;
            m_p  <= (m_op == OP_FIRST) ? m_m : (m_p + m_m);
        end
    end
    assign dsp_p = m_p;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard and per-job activity counters, sampled 1 time unit after negedge.
    logic [47:0] sb_q[$];
    int cyc = 0, busy_cnt = 0, en_cnt = 0, op_first_cnt = 0, step_first_cnt = 0;
    int first_op_cyc = -1, first_issue_cyc = -1;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (dsp_enable) en_cnt++;
        if (dsp_opmode == OP_FIRST) begin
            op_first_cnt++;
            if (first_op_cyc < 0) first_op_cyc = cyc;
        end
        if (dsp_enable && dsp_opmode == OP_FIRST) step_first_cnt++;
        if (rst_n && in_ready && !in_valid) check("gap_enable", 64'(dsp_enable), 64'd0);
        if (rst_n && in_valid && in_ready) begin
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            check("dsp_a_sext", 64'(dsp_a), 64'({{3{in_a[26]}}, in_a}));
            check("dsp_b", 64'(dsp_b), 64'(in_b));
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 64'(out_data), 64'hDEAD);
            end else begin
                check("out_data", 64'(out_data), 64'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        string       name;
        int          len;
        int          a[6];
        int          b[6];
        int          pat_len;    // 0 = in_valid held high
        bit          pat[6];
        logic [47:0] exp;
    } vec_t;

    vec_t vt[6];
    int   wait_cycles;

    task automatic clr_counts();
        busy_cnt = 0; en_cnt = 0; op_first_cnt = 0; step_first_cnt = 0;
        first_op_cyc = -1; first_issue_cyc = -1;
    endtask

    // Issue a job and stream its operands; returns on the first cycle out_valid is seen.
    task automatic run_vec(input vec_t v);
        int i = 0, k = 0, guard = 0;
        @(negedge clk);
        clr_counts();
        sb_q.push_back(v.exp);
        start = 1'b1;
        len   = 16'(v.len);
        @(negedge clk);
        start = 1'b0;
        while (i < v.len && guard < 2000) begin
            in_valid = (v.pat_len == 0) ? 1'b1 : v.pat[k % v.pat_len];
            in_a = 27'(v.a[i % 6]);
            in_b = 18'(v.b[i % 6]);
            if (in_valid && in_ready) i++;
            k++;
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_cycles = 0;
        while (!out_valid && wait_cycles < 300) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!out_valid) check({v.name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0].name = "seq3";    vt[0].len = 3;  vt[0].a = '{2, 3, 4, 0, 0, 0};
        vt[0].b = '{5, 6, 7, 0, 0, 0};   vt[0].pat_len = 0; vt[0].pat = '{1, 1, 1, 1, 1, 1};
        vt[0].exp = 48'd56;
        vt[1].name = "neg1";    vt[1].len = 1;  vt[1].a = '{-1, 0, 0, 0, 0, 0};
        vt[1].b = '{100, 0, 0, 0, 0, 0}; vt[1].pat_len = 0; vt[1].pat = '{1, 1, 1, 1, 1, 1};
        vt[1].exp = -48'sd100;
        vt[2].name = "gaps";    vt[2].len = 3;  vt[2].a = '{2, 3, 4, 0, 0, 0};
        vt[2].b = '{5, 6, 7, 0, 0, 0};   vt[2].pat_len = 6; vt[2].pat = '{1, 0, 0, 1, 0, 1};
        vt[2].exp = 48'd56;
        vt[3].name = "extreme"; vt[3].len = 2;  vt[3].a = '{67108863, -67108864, 0, 0, 0, 0};
        vt[3].b = '{-131072, -131072, 0, 0, 0, 0}; vt[3].pat_len = 0; vt[3].pat = '{1, 1, 1, 1, 1, 1};
        vt[3].exp = 48'd131072;
        // 40 * 2^43 = 2^48 + 2^46, which wraps to 2^46.
        vt[4].name = "wrap";    vt[4].len = 40;
        vt[4].a = '{-67108864, -67108864, -67108864, -67108864, -67108864, -67108864};
        vt[4].b = '{-131072, -131072, -131072, -131072, -131072, -131072};
        vt[4].pat_len = 0; vt[4].pat = '{1, 1, 1, 1, 1, 1};
        vt[4].exp = 48'h4000_0000_0000;
        vt[5].name = "len0";    vt[5].len = 0;  vt[5].a = '{0, 0, 0, 0, 0, 0};
        vt[5].b = '{0, 0, 0, 0, 0, 0};   vt[5].pat_len = 0; vt[5].pat = '{1, 1, 1, 1, 1, 1};
        vt[5].exp = 48'd0;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dsp_rst",   64'(dsp_rst), 64'd1);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_enable",    64'(dsp_enable), 64'd0);
        check("rst_out_data",  64'(out_data), 64'd0);
        check("rst_opmode",    64'(dsp_opmode), 64'(OP_ACC));
        rst_n = 1'b1;
        @(negedge clk);
        check("dsp_rst_idle", 64'(dsp_rst), 64'd0);
        check("const_c",      64'(dsp_c), 64'd0);
        check("const_d",      64'(dsp_d), 64'd0);
        check("const_inmode", 64'(dsp_inmode), 64'd0);
        check("const_alumode", 64'(dsp_alumode), 64'd0);

        // Table-driven jobs with out_ready held high.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            run_vec(vt[v]);
            @(negedge clk);
            check({vt[v].name, "_busy_drop"}, 64'(busy), 64'd0);
            if (vt[v].len == 0) begin
                check("len0_latency", 64'(wait_cycles), 64'd0);
                check("len0_enable",  64'(en_cnt), 64'd0);
            end else begin
                check({vt[v].name, "_en_steps"},   64'(en_cnt), 64'(vt[v].len + 3));
                check({vt[v].name, "_first_steps"}, 64'(step_first_cnt), 64'd1);
                if (vt[v].pat_len == 0) begin
                    check({vt[v].name, "_busy_cycles"}, 64'(busy_cnt), 64'(vt[v].len + 5));
                    check({vt[v].name, "_first_cycles"}, 64'(op_first_cnt), 64'd1);
                    check({vt[v].name, "_first_align"},
                          64'(first_op_cyc - first_issue_cyc), 64'd1);
                end
            end
        end

        // Result held under back-pressure; starts during OUT are ignored.
        out_ready = 1'b0;
        run_vec(vt[0]);
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data",  64'(out_data), 64'd56);
            start = (c == 3 || c == 4);
            len   = 16'd2;
            @(negedge clk);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("release_busy",  64'(busy), 64'd0);
        check("release_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("same_cycle_start_ignored", 64'(busy), 64'd0);

        // Reset mid-RUN after 2 of 5 pairs abandons the job.
        begin
            int i = 0, guard = 0;
            clr_counts();
            start = 1'b1;
            len   = 16'd5;
            @(negedge clk);
            start = 1'b0;
            while (i < 2 && guard < 50) begin
                in_valid = 1'b1;
                in_a = 27'd9;
                in_b = 18'd9;
                if (in_ready) i++;
                guard++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("midrun_busy", 64'(busy), 64'd1);
            rst_n = 1'b0;
            #1;
            check("midrun_dsp_rst", 64'(dsp_rst), 64'd1);
            @(negedge clk);
            check("midrun_rst_busy",      64'(busy), 64'd0);
            check("midrun_rst_in_ready",  64'(in_ready), 64'd0);
            check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
            check("midrun_rst_enable",    64'(dsp_enable), 64'd0);
            check("midrun_rst_out_data",  64'(out_data), 64'd0);
            check("midrun_rst_opmode",    64'(dsp_opmode), 64'(OP_ACC));
            rst_n = 1'b1;
            @(negedge clk);
        end
        begin
            vec_t fv;
            fv = vt[0];
            fv.name = "post_rst";
            fv.len  = 2;
            fv.a    = '{1, 1, 0, 0, 0, 0};
            fv.b    = '{3, 4, 0, 0, 0, 0};
            fv.exp  = 48'd7;
            run_vec(fv);
            @(negedge clk);
            check("post_rst_busy_drop", 64'(busy), 64'd0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_dot_sequencer.md
Name: dsp_dot_sequencer

Overview:
- Sequences one DSP48E2 slice, through the team's DSP wrapper, to compute signed dot products of a programmable length: P = sum of a[i]*b[i], i = 0..len-1.
- Accepts a job on a start pulse and streams operand pairs in with valid/ready.
- Drives the wrapper's A/B/C/D, OPMODE/INMODE/ALUMODE, enable and reset pins, aligning OPMODE to the slice pipeline.
- Returns the 48-bit result with valid/ready.
- Sits between the TPU tile's operand feeders and a single DSP instance.

Parameters:
- INPUTREG, 1, must equal the wrapper's INPUTREG (A/B register depth).
- DSPPIPEREG, 1, must equal the wrapper's DSPPIPEREG (M register).
- OUTPUTREG, 1, must equal the wrapper's OUTPUTREG (P register).
- CONTROLREG, 1, must equal the wrapper's CONTROLREG. Requires INPUTREG+DSPPIPEREG >= CONTROLREG.
- LEN_W, 16, width of the job length.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  job start pulse; honoured only when busy=0.
- len  in  LEN_W  number of operand pairs, sampled with start.
- busy  out  1  high from the accepted start until the result handshake completes.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_a  in  27  signed multiplicand.
- in_b  in  18  signed multiplier.
- dsp_rst  out  1  wrapper rst (active-high); equals ~rst_n, combinational.
- dsp_enable  out  1  wrapper enable; advances the entire slice.
- dsp_a  out  30  in_a sign-extended to 30 bits.
- dsp_b  out  18  in_b.
- dsp_c  out  48  constant 0.
- dsp_d  out  27  constant 0.
- dsp_opmode  out  9  slot opmode.
- dsp_inmode  out  5  constant 5'b00000 (A2*B2, pre-adder D unused).
- dsp_alumode  out  4  constant 4'b0000 (add).
- dsp_p  in  48  wrapper P.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  48  signed dot product.

Behaviour:
- Derived constants:
  - OPDLY = INPUTREG + DSPPIPEREG - CONTROLREG
  - LAT = INPUTREG + DSPPIPEREG + OUTPUTREG
  - Defaults give OPDLY = 1 and LAT = 3.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, in_ready, out_valid, dsp_enable = 0; out_data = 0.
  - Counters cleared; opmode delay line filled with ACC.
  - Reset mid-job abandons the job; no result is produced.
- Opmodes:
  - FIRST = 9'h005 (P = M).
  - ACC = 9'h025 (P = P + M).
- Step definition: a "step" is a clk edge with dsp_enable=1. The opmode delay line (OPDLY entries, bypassed when OPDLY=0) and the drain counter advance only on steps, so the DSP and the controller stall together.
- Slot tagging:
  - Each step inserts a tag into the delay line: FIRST for the first pair of a job, ACC otherwise.
  - dsp_opmode is the delay-line output.
  - Bubble/drain slots present dsp_a = dsp_b = 0 with tag ACC, so P holds.
- IDLE:
  - dsp_enable = 0, in_ready = 0.
  - start with len>0: latch len into remaining, go to RUN, busy = 1.
  - start with len=0: out_data = 0, go to OUT (no DSP activity).
- RUN:
  - in_ready = 1; dsp_enable = in_valid.
  - On a handshake, dsp_a/dsp_b carry the operands in the same cycle and remaining decrements.
  - The handshake that takes remaining to 0 moves to DRAIN with drain count = LAT.
  - in_valid=0 means no step: the pipeline freezes.
- DRAIN:
  - in_ready = 0; dsp_enable = 1; zero operands issued.
  - Drain count decrements each step.
  - When the count reaches 0, the next cycle captures dsp_p into out_data and moves to OUT. The captured value is the final P.
- OUT:
  - out_valid = 1; dsp_enable = 0; out_data held stable.
  - On out_ready: out_valid = 0, busy = 0, go to IDLE.
  - A start asserted in the same cycle is ignored; start is honoured from IDLE on the following cycle.
- Widths: the 27x18 product accumulates in 48 bits; overflow wraps (two's complement), no saturation.
- start is ignored while busy=1.

Test Plan:
- len=3, a=(2,3,4), b=(5,6,7), in_valid constant, out_ready=1 -> out_data=56. busy asserts for exactly 3 + LAT + 2 cycles (IDLE-to-RUN, 3 issue cycles, LAT drain cycles, capture, OUT). dsp_opmode is 9'h005 for exactly one cycle, OPDLY steps after the first issue.
- Back-to-back jobs: job 1 as above, then len=1, a=-1, b=100 -> out_data=-100. Proves FIRST clears the previous accumulation.
- in_valid toggles 1,0,0,1,0,1 on the len=3 job -> dsp_enable=0 on the gap cycles, same result 56, no extra opmode FIRST.
- out_ready held 0 for 10 cycles -> out_valid and out_data=56 stable, start pulses ignored. Release -> busy drops the next cycle.
- len=0 -> out_valid the cycle after start with out_data=0, dsp_enable never asserted.
- rst_n=0 for one cycle mid-RUN after 2 of 5 pairs -> all outputs at reset values, dsp_rst=1 during reset. A fresh len=2 job (a=(1,1), b=(3,4)) -> 7.
